ppg_beat_detect: RTL

//  Consumes the signed, zero-centred AC stream from ppg_filter. It detects systolic peaks with an

---
 rtl/ppg_beat_detect.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ppg_beat_detect.sv
// ppg_beat_detect: systolic peak detector for the zero-centred PPG AC stream.
// It uses an adaptive threshold, a refractory window and inter-beat interval
// measurement. The IBI is converted to beats per minute by a sequential
// restoring divider.
module ppg_beat_detect #(
    parameter int DATA_WIDTH  = 18,
    parameter int SAMPLE_RATE = 100,
    parameter int MIN_IBI     = 30,
    parameter int MAX_IBI     = 200,
    parameter int THRESH_MIN  = 64,
    parameter int IBI_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_data_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_beat,
    output logic [IBI_WIDTH-1:0]         o_ibi,
    output logic [7:0]                   o_bpm,
    output logic                         o_bpm_valid,
    output logic                         o_locked
);

    localparam logic [IBI_WIDTH-1:0]         BPM_NUM      = IBI_WIDTH'(60 * SAMPLE_RATE);
    localparam logic [IBI_WIDTH-1:0]         MIN_CNT      = IBI_WIDTH'(MIN_IBI);
    localparam logic [IBI_WIDTH-1:0]         MAX_CNT      = IBI_WIDTH'(MAX_IBI);
    localparam logic signed [DATA_WIDTH-1:0] THRESH_FLOOR = DATA_WIDTH'(THRESH_MIN);
    localparam logic signed [DATA_WIDTH-1:0] ZERO         = '0;
    localparam int                           ITER_W       = $clog2(IBI_WIDTH + 1);
    localparam logic [ITER_W-1:0]            ITER_LAST    = ITER_W'(IBI_WIDTH);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        REFRACT
    } state_e;

    // Detection state
    state_e                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   thresh_q, thresh_d;
    logic signed [DATA_WIDTH-1:0]   pk_q, pk_d;
    logic signed [DATA_WIDTH-1:0]   pk_half;
    logic [IBI_WIDTH-1:0]           cnt_q, cnt_d;
    logic [IBI_WIDTH-1:0]           cnt_inc;
    logic                           have_prev_q, have_prev_d;
    logic                           beat_q, beat_d;
    logic [IBI_WIDTH-1:0]           ibi_q, ibi_d;
    logic                           locked_q, locked_d;
    logic                           timeout;
    logic                           div_start;

    // Divider state
    logic                           div_busy_q, div_busy_d;
    logic [ITER_W-1:0]              div_iter_q, div_iter_d;
    logic [IBI_WIDTH-1:0]           div_rem_q, div_rem_d;
    logic [IBI_WIDTH-1:0]           div_quo_q, div_quo_d;
    logic [IBI_WIDTH-1:0]           div_den_q, div_den_d;
    logic [IBI_WIDTH:0]             rem_shift;
    logic [IBI_WIDTH:0]             rem_sub;
    logic [7:0]                     bpm_q, bpm_d;
    logic                           bpm_valid_q, bpm_valid_d;

    assign pk_half = pk_q >>> 1;

    // cnt_inc already includes the sample being processed, so it is the IBI
    // in samples measured between two detection samples.
    assign cnt_inc = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + IBI_WIDTH'(1);

    // Peak detection FSM, interval counter and timeout handling (per sample)
    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        pk_d        = pk_q;
        cnt_d       = cnt_q;
        have_prev_d = have_prev_q;
        beat_d      = 1'b0;
        ibi_d       = ibi_q;
        locked_d    = locked_q;
        timeout     = 1'b0;
        div_start   = 1'b0;
        if (i_data_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= MAX_CNT) begin
                // Loss of lock overrides whatever the FSM would have done
                timeout     = 1'b1;
                state_d     = SEARCH;
                cnt_d       = '0;
                have_prev_d = 1'b0;
                thresh_d    = THRESH_FLOOR;
                locked_d    = 1'b0;
            end else begin
                case (state_q)
                    SEARCH: begin
                        if (i_data > thresh_q) begin
                            state_d = TRACK;
                            pk_d    = i_data;
                        end
                    end
                    TRACK: begin
                        if (i_data >= pk_q) begin
                            pk_d = i_data;
                        end else if (have_prev_q && (cnt_inc < MIN_CNT)) begin
                            // Too soon after the last beat: treat as artefact
                            state_d = SEARCH;
                        end else begin
                            beat_d      = 1'b1;
                            cnt_d       = '0;
                            thresh_d    = (pk_half > THRESH_FLOOR) ? pk_half : THRESH_FLOOR;
                            state_d     = REFRACT;
                            have_prev_d = 1'b1;
                            if (have_prev_q) begin
                                ibi_d     = cnt_inc;
                                locked_d  = 1'b1;
                                div_start = 1'b1;
                            end
                        end
                    end
                    REFRACT: begin
                        if (i_data <= ZERO) begin
                            state_d = SEARCH;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    assign rem_shift = {div_rem_q, div_quo_q[IBI_WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, div_den_q};

    // Restoring divider: one quotient bit per clock, result published one
    // clock after the last iteration; timeout forces a zero result.
    always_comb begin
        div_busy_d  = div_busy_q;
        div_iter_d  = div_iter_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_den_d   = div_den_q;
        bpm_d       = bpm_q;
        bpm_valid_d = 1'b0;
        if (timeout) begin
            div_busy_d  = 1'b0;
            bpm_d       = '0;
            bpm_valid_d = 1'b1;
        end else if (div_start) begin
            div_busy_d = 1'b1;
            div_iter_d = '0;
            div_rem_d  = '0;
            div_quo_d  = BPM_NUM;
            div_den_d  = cnt_inc;
        end else if (div_busy_q) begin
            if (div_iter_q == ITER_LAST) begin
                div_busy_d  = 1'b0;
                bpm_d       = (div_quo_q > IBI_WIDTH'(255)) ? 8'hFF : div_quo_q[7:0];
                bpm_valid_d = 1'b1;
            end else begin
                div_iter_d = div_iter_q + ITER_W'(1);
                if (!rem_sub[IBI_WIDTH]) begin
                    div_rem_d = rem_sub[IBI_WIDTH-1:0];
                    div_quo_d = {div_quo_q[IBI_WIDTH-2:0], 1'b1};
                end else begin
                    div_rem_d = rem_shift[IBI_WIDTH-1:0];
                    div_quo_d = {div_quo_q[IBI_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            thresh_q    <= THRESH_FLOOR;
            pk_q        <= '0;
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
            beat_q      <= 1'b0;
            ibi_q       <= '0;
            locked_q    <= 1'b0;
            div_busy_q  <= 1'b0;
            div_iter_q  <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_den_q   <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            pk_q        <= pk_d;
            cnt_q       <= cnt_d;
            have_prev_q <= have_prev_d;
            beat_q      <= beat_d;
            ibi_q       <= ibi_d;
            locked_q    <= locked_d;
            div_busy_q  <= div_busy_d;
            div_iter_q  <= div_iter_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_den_q   <= div_den_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
        end
    end

    assign o_beat      = beat_q;
    assign o_ibi       = ibi_q;
    assign o_bpm       = bpm_q;
    assign o_bpm_valid = bpm_valid_q;
    assign o_locked    = locked_q;

endmodule
